seg_scan: RTL and testbench



---
 rtl/banner_pkg.sv | 30 +++
 rtl/seg_decode.sv | 27 ++
 rtl/seg_scan.sv | 104 ++++++++++
 tb/tb_seg_scan.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banner_pkg.sv
// Digit codes and active-low segment patterns shared by the banner stage and seg_scan.
package banner_pkg;

    localparam logic [3:0] ZERO  = 4'h0;
    localparam logic [3:0] ONE   = 4'h1;
    localparam logic [3:0] TWO   = 4'h2;
    localparam logic [3:0] THREE = 4'h3;
    localparam logic [3:0] FOUR  = 4'h4;
    localparam logic [3:0] FIVE  = 4'h5;
    localparam logic [3:0] SIX   = 4'h6;
    localparam logic [3:0] SEVEN = 4'h7;
    localparam logic [3:0] EIGHT = 4'h8;
    localparam logic [3:0] NINE  = 4'h9;
    localparam logic [3:0] NULL  = 4'hF;

    // Segment order g,f,e,d,c,b,a; a cleared bit lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit code to active-low 7-segment pattern; codes A-E show a dash.
module seg_decode
    import banner_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (code)
            ZERO:    seg = SEG_0;
            ONE:     seg = SEG_1;
            TWO:     seg = SEG_2;
            THREE:   seg = SEG_3;
            FOUR:    seg = SEG_4;
            FIVE:    seg = SEG_5;
            SIX:     seg = SEG_6;
            SEVEN:   seg = SEG_7;
            EIGHT:   seg = SEG_8;
            NINE:    seg = SEG_9;
            NULL:    seg = SEG_BLANK;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display with frame latch.
// Optional SEG_SCAN_PWM_EN adds a duty[2:0] brightness input.
module seg_scan
    import banner_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 65536,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] dig_0,
    input  logic [3:0] dig_1,
    input  logic [3:0] dig_2,
    input  logic [3:0] dig_3,
    input  logic [3:0] dp_in,
`ifdef SEG_SCAN_PWM_EN
    input  logic [2:0] duty,
`endif
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int unsigned   CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [3:0]    frame_dig [4];
    logic [3:0]    frame_dp;
    logic [3:0]    cur_code;
    logic [6:0]    cur_seg;
    logic          slot_on;
    logic          frame_load;
`ifdef SEG_SCAN_PWM_EN
    logic [2:0]    frame_duty;
`endif

    always_comb cur_code = frame_dig[idx];

    seg_decode u_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // While disabled the latch tracks the inputs, so re-enabling shows the latest frame.
    assign frame_load = !enable || ((cnt == CNT_LAST) && (idx == 2'd3));

    always_comb begin
        slot_on = (cnt >= BLANK_END);
`ifdef SEG_SCAN_PWM_EN
        if (cnt[CW-1 -: 3] > frame_duty) slot_on = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            idx  <= '0;
            an   <= '1;
            sseg <= '1;
        end else if (!enable) begin
            cnt  <= '0;
            idx  <= '0;
            an   <= '1;
            sseg <= '1;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (slot_on) begin
                an   <= ~(4'b0001 << idx);
                sseg <= {~frame_dp[idx], cur_seg};
            end else begin
                an   <= '1;
                sseg <= '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 4; i++) frame_dig[i] <= NULL;
            frame_dp <= '0;
`ifdef SEG_SCAN_PWM_EN
            frame_duty <= '1;
`endif
        end else if (frame_load) begin
            frame_dig[0] <= dig_0;
            frame_dig[1] <= dig_1;
            frame_dig[2] <= dig_2;
            frame_dig[3] <= dig_3;
            frame_dp     <= dp_in;
`ifdef SEG_SCAN_PWM_EN
            frame_duty   <= duty;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: frame vector table, corner sequences, randomized run vs model.
module tb_seg_scan;

    localparam int RD    = 16;
    localparam int BL    = 2;
    localparam int FRAME = 4 * RD;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] dig_0 = 4'hF, dig_1 = 4'hF, dig_2 = 4'hF, dig_3 = 4'hF;
    logic [3:0] dp_in = 4'h0;
    logic [3:0] an;
    logic [7:0] sseg;
`ifdef SEG_SCAN_PWM_EN
    logic [2:0] duty = 3'd7;
`endif

    int checks = 0;
    int passes = 0;

    seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .dig_0  (dig_0),
        .dig_1  (dig_1),
        .dig_2  (dig_2),
        .dig_3  (dig_3),
        .dp_in  (dp_in),
`ifdef SEG_SCAN_PWM_EN
        .duty   (duty),
`endif
        .an     (an),
        .sseg   (sseg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hF: return 7'h7F;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: position within the 64-cycle frame plus a snapshot of the displayed frame.
    int         m_pos;
    int         m_off;
    logic [1:0] m_slot;
    bit         m_lit;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp;
    logic [2:0] m_duty;
    logic [3:0] m_an;
    logic [7:0] m_sseg;
    bit         m_chk = 0;

    task automatic model_capture();
        m_dig[0] = dig_0; m_dig[1] = dig_1; m_dig[2] = dig_2; m_dig[3] = dig_3;
        m_dp = dp_in;
`ifdef SEG_SCAN_PWM_EN
        m_duty = duty;
`endif
    endtask

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_pos = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
            m_dp = 4'h0; m_duty = 3'd7;
            m_an = 4'hF; m_sseg = 8'hFF;
        end else if (!enable) begin
            m_pos = 0;
            model_capture();
            m_an = 4'hF; m_sseg = 8'hFF;
        end else begin
            m_off  = m_pos % RD;
            m_slot = 2'(m_pos / RD);
            m_lit  = (m_off >= BL);
`ifdef SEG_SCAN_PWM_EN
            if ((m_off * 8) / RD > int'(m_duty)) m_lit = 0;
`endif
            if (m_lit) begin
                m_an   = 4'hF ^ (4'h1 << m_slot);
                m_sseg = {~m_dp[m_slot], ref_seg(m_dig[m_slot])};
            end else begin
                m_an = 4'hF; m_sseg = 8'hFF;
            end
            if (m_pos == FRAME - 1) model_capture();
            m_pos = (m_pos + 1) % FRAME;
        end
    end

    always @(negedge clk) begin
        if (m_chk) begin
            check("model_an", 32'(an), 32'(m_an));
            check("model_sseg", 32'(sseg), 32'(m_sseg));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_digs(input logic [15:0] d, input logic [3:0] dp);
        dig_3 = d[15:12]; dig_2 = d[11:8]; dig_1 = d[7:4]; dig_0 = d[3:0];
        dp_in = dp;
    endtask

    // Load a frame through the disabled latch, then start scanning from slot 0.
    task automatic start_frame(input logic [15:0] d, input logic [3:0] dp);
        enable = 1'b0;
        set_digs(d, dp);
        tick(); tick();
        enable = 1'b1;
    endtask

    typedef struct {
        logic [15:0] digs;
        logic [3:0]  dp;
        logic [31:0] sseg;
    } vec_t;

    vec_t        vecs [5];
    logic [15:0] slot_an = 16'h7BDE;
    int          bad;
    int          n;
    int          lit_cnt;
    int          first_on;

    initial begin
        vecs[0] = '{16'h3210, 4'b0000, 32'hB0A4F9C0};
        vecs[1] = '{16'h7654, 4'b0000, 32'hF8829299};
        vecs[2] = '{16'hFB98, 4'b0100, 32'hFF3F9080};
        vecs[3] = '{16'hAECD, 4'b1111, 32'h3F3F3F3F};
        vecs[4] = '{16'hFFFF, 4'b1001, 32'h7FFFFF7F};

        repeat (2) tick();
        check("reset_an", 32'(an), 32'h0000000F);
        check("reset_sseg", 32'(sseg), 32'h000000FF);
        reset = 1'b1;
        m_chk = 1;

        foreach (vecs[v]) begin
            start_frame(vecs[v].digs, vecs[v].dp);
            for (int k = 0; k < FRAME; k++) begin
                tick();
                if (k % RD == 0) begin
                    check("vec_blank_an", 32'(an), 32'h0000000F);
                    check("vec_blank_sseg", 32'(sseg), 32'h000000FF);
                end else if (k % RD == BL || k % RD == RD - 1) begin
                    check("vec_an", 32'(an), 32'(slot_an[(k / RD) * 4 +: 4]));
                    check("vec_sseg", 32'(sseg), 32'(vecs[v].sseg[(k / RD) * 8 +: 8]));
                end
            end
        end

        // Asynchronous reset in the middle of a slot.
        repeat (5) tick();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'h0000000F);
        check("async_reset_sseg", 32'(sseg), 32'h000000FF);
        @(negedge clk);
        set_digs(16'hFFFF, 4'b0000);
        enable = 1'b1;
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (sseg !== 8'hFF) bad++;
            if (k == BL) check("resume_idx0_an", 32'(an), 32'h0000000E);
        end
        check("null_frame_blank", 32'(bad), 32'd0);

        // Mid-frame input change appears only in the following frame.
        start_frame(16'h3210, 4'b0000);
        for (int k = 0; k < FRAME + RD; k++) begin
            tick();
            if (k == RD + 5) dig_0 = 4'h9;
            if (k == 5) check("frame0_slot0", 32'(sseg), 32'h000000C0);
            if (k == 2 * RD + 5) check("frame0_slot2", 32'(sseg), 32'h000000A4);
            if (k == 3 * RD + 5) check("frame0_slot3", 32'(sseg), 32'h000000B0);
            if (k == FRAME + 5) begin
                check("frame1_slot0_an", 32'(an), 32'h0000000E);
                check("frame1_slot0_sseg", 32'(sseg), 32'h00000090);
            end
        end

        // Dash with dp, disable mid-slot 2, then re-enable latency.
        start_frame(16'h3B10, 4'b0100);
        for (int k = 0; k <= 2 * RD + 5; k++) tick();
        check("dash_dp_an", 32'(an), 32'h0000000B);
        check("dash_dp_sseg", 32'(sseg), 32'h0000003F);
        enable = 1'b0;
        tick();
        check("disable_an", 32'(an), 32'h0000000F);
        check("disable_sseg", 32'(sseg), 32'h000000FF);
        tick();
        enable = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n++;
            if (an !== 4'hF) break;
        end
        check("reenable_latency", 32'(n), 32'd3);
        check("reenable_an", 32'(an), 32'h0000000E);
        check("reenable_sseg", 32'(sseg), 32'h000000C0);

`ifdef SEG_SCAN_PWM_EN
        for (int d = 0; d < 3; d++) begin
            duty = (d == 0) ? 3'd1 : (d == 1) ? 3'd7 : 3'd0;
            start_frame(16'h3210, 4'b0000);
            lit_cnt = 0;
            first_on = -1;
            for (int k = 0; k < RD; k++) begin
                tick();
                if (an !== 4'hF) begin
                    lit_cnt++;
                    if (first_on < 0) first_on = k;
                end
            end
            check("pwm_lit_count", 32'(lit_cnt), (d == 0) ? 32'd2 : (d == 1) ? 32'd14 : 32'd0);
            if (d != 2) check("pwm_first_on", 32'(first_on), 32'(BL));
        end
        duty = 3'd7;
`endif

        // Randomized run against the model.
        start_frame(16'h0123, 4'b0000);
        for (int k = 0; k < 2000; k++) begin
            tick();
            if ($urandom_range(0, 7) == 0) dig_0 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) dig_1 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) dig_2 = 4'($urandom);
            if ($urandom_range(0, 7) == 0) dig_3 = 4'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
`ifdef SEG_SCAN_PWM_EN
            if ($urandom_range(0, 31) == 0) duty = 3'($urandom);
`endif
            if (enable) begin
                if ($urandom_range(0, 99) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                enable = 1'b1;
            end
        end

        m_chk = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
